// File: rtl/fli_result_queue_if.sv
// Handshake bundle between the FLI generator, the result queue and FP writeback.
interface fli_result_queue_if #(
   parameter int unsigned FLEN    = 64,
   parameter int unsigned FMTBITS = 2,
   parameter int unsigned DEPTH   = 2
);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic               InValid;
   logic               InReady;
   logic [FLEN-1:0]    ImmE;
   logic [FMTBITS-1:0] FmtE;
   logic [4:0]         RdE;
   logic               Flush;
   logic               OutValid;
   logic               OutReady;
   logic [FLEN-1:0]    ImmW;
   logic [FMTBITS-1:0] FmtW;
   logic [4:0]         RdW;
   logic               BoxErr;
   logic [CW-1:0]      Count;

   modport master (
      output InValid, ImmE, FmtE, RdE, Flush, OutReady,
      input  InReady, OutValid, ImmW, FmtW, RdW, BoxErr, Count
   );

   modport slave (
      input  InValid, ImmE, FmtE, RdE, Flush, OutReady,
      output InReady, OutValid, ImmW, FmtW, RdW, BoxErr, Count
   );
endinterface

// File: rtl/fli_result_queue.sv
// In-order result queue for Zfa fli immediates; flags entries whose NaN-boxing
// does not match their format. All outputs come straight from flops.
module fli_result_queue #(
   parameter int unsigned FLEN    = 64,
   parameter int unsigned FMTBITS = 2,
   parameter int unsigned DEPTH   = 2
) (
   input logic clk,
   input logic reset_n,
   fli_result_queue_if.slave q
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [FLEN-1:0]    imm_mem [DEPTH];
   logic [FMTBITS-1:0] fmt_mem [DEPTH];
   logic [4:0]         rd_mem  [DEPTH];
   logic               err_mem [DEPTH];

   logic [AW-1:0] wptr, rptr, wptr_n, rptr_n;
   logic [CW-1:0] count_n;
   logic          push_c, pop_c, in_err_c;
   logic          in_ready_n, out_valid_n, err_n;
   logic [FLEN-1:0]    imm_n;
   logic [FMTBITS-1:0] fmt_n;
   logic [4:0]         rd_n;

   // Bits above the format's width must all be 1; unsupported formats always fail.
   function automatic logic box_err(input logic [FLEN-1:0] imm, input logic [FMTBITS-1:0] fmt);
      int unsigned lo;
      logic        ok;
      ok = 1'b1;
      lo = FLEN;
      if (fmt == FMTBITS'(0))      lo = 32;
      else if (fmt == FMTBITS'(1)) begin lo = 64; if (FLEN < 64) ok = 1'b0; end
      else if (fmt == FMTBITS'(2)) lo = 16;
      else if (fmt == FMTBITS'(3)) begin if (FLEN != 128) ok = 1'b0; end
      else                         ok = 1'b0;
      for (int unsigned i = 0; i < FLEN; i++)
         if (i >= lo && !imm[i]) ok = 1'b0;
      return !ok;
   endfunction

   assign push_c   = q.InValid & q.InReady;
   assign pop_c    = q.OutValid & q.OutReady;
   assign in_err_c = box_err(q.ImmE, q.FmtE);

   always_comb begin
      wptr_n  = wptr;
      rptr_n  = rptr;
      count_n = q.Count;
      imm_n   = '0;
      fmt_n   = '0;
      rd_n    = '0;
      err_n   = 1'b0;
      if (q.Flush) begin
         wptr_n  = '0;
         rptr_n  = '0;
         count_n = '0;
      end else begin
         if (push_c) wptr_n = wptr + AW'(1);
         if (pop_c)  rptr_n = rptr + AW'(1);
         count_n = q.Count + CW'(push_c) - CW'(pop_c);
      end
      // Next head is the incoming entry only when it lands exactly at the new read pointer.
      if (count_n != '0) begin
         if (push_c && !q.Flush && rptr_n == wptr) begin
            imm_n = q.ImmE;
            fmt_n = q.FmtE;
            rd_n  = q.RdE;
            err_n = in_err_c;
         end else begin
            imm_n = imm_mem[rptr_n];
            fmt_n = fmt_mem[rptr_n];
            rd_n  = rd_mem[rptr_n];
            err_n = err_mem[rptr_n];
         end
      end
      in_ready_n  = (count_n != CW'(DEPTH));
      out_valid_n = (count_n != '0);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wptr       <= '0;
         rptr       <= '0;
         q.Count    <= '0;
         q.InReady  <= 1'b1;
         q.OutValid <= 1'b0;
         q.ImmW     <= '0;
         q.FmtW     <= '0;
         q.RdW      <= '0;
         q.BoxErr   <= 1'b0;
      end else begin
         wptr       <= wptr_n;
         rptr       <= rptr_n;
         q.Count    <= count_n;
         q.InReady  <= in_ready_n;
         q.OutValid <= out_valid_n;
         q.ImmW     <= imm_n;
         q.FmtW     <= fmt_n;
         q.RdW      <= rd_n;
         q.BoxErr   <= err_n;
      end
   end

   // Entry storage needs no reset; validity is tracked by Count.
   always_ff @(posedge clk) begin
      if (push_c && !q.Flush) begin
         imm_mem[wptr] <= q.ImmE;
         fmt_mem[wptr] <= q.FmtE;
         rd_mem[wptr]  <= q.RdE;
         err_mem[wptr] <= in_err_c;
      end
   end
endmodule

// File: tb/tb_fli_result_queue.sv
// Randomised and directed bench for fli_result_queue against a queue-based model.
module tb_fli_result_queue;
   localparam int unsigned FLEN  = 64;
   localparam int unsigned DEPTH = 2;

   typedef struct {
      logic [63:0] imm;
      logic [1:0]  fmt;
      logic [4:0]  rd;
      logic        err;
   } entry_t;

   logic clk = 1'b0;
   logic reset_n;
   int   total = 0;
   int   bad   = 0;
   entry_t mq[$];

   fli_result_queue_if #(.FLEN(FLEN), .FMTBITS(2), .DEPTH(DEPTH)) bus ();
   fli_result_queue #(.FLEN(FLEN), .FMTBITS(2), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset_n(reset_n), .q(bus));

   always #5 clk = ~clk;

   function automatic logic exp_err(input logic [63:0] imm, input logic [1:0] fmt);
      case (fmt)
         2'b00:   return imm[63:32] != 32'hFFFF_FFFF;
         2'b01:   return 1'b0;
         2'b10:   return imm[63:16] != {48{1'b1}};
         default: return 1'b1;
      endcase
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: plain FIFO of entries, capacity DEPTH.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mq.delete();
      end else begin
         bit psh, pp;
         entry_t e;
         psh = bus.InValid && (mq.size() != DEPTH);
         pp  = (mq.size() != 0) && bus.OutReady;
         if (bus.Flush) mq.delete();
         else begin
            if (pp) void'(mq.pop_front());
            if (psh) begin
               e.imm = bus.ImmE; e.fmt = bus.FmtE; e.rd = bus.RdE;
               e.err = exp_err(bus.ImmE, bus.FmtE);
               mq.push_back(e);
            end
         end
      end
   end

   always @(negedge clk) begin
      entry_t h;
      h = '{imm: 64'h0, fmt: 2'b0, rd: 5'd0, err: 1'b0};
      if (mq.size() != 0) h = mq[0];
      chk("count",    64'(bus.Count),    64'(mq.size()));
      chk("outvalid", 64'(bus.OutValid), 64'(mq.size() != 0));
      chk("inready",  64'(bus.InReady),  64'(mq.size() != DEPTH));
      chk("immw",     bus.ImmW,          h.imm);
      chk("fmtw",     64'(bus.FmtW),     64'(h.fmt));
      chk("rdw",      64'(bus.RdW),      64'(h.rd));
      chk("boxerr",   64'(bus.BoxErr),   64'(h.err));
   end

   task automatic drive(input logic v, input logic [63:0] imm, input logic [1:0] fmt,
                        input logic [4:0] rd, input logic fl, input logic ordy);
      bus.InValid = v; bus.ImmE = imm; bus.FmtE = fmt; bus.RdE = rd;
      bus.Flush = fl; bus.OutReady = ordy;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n = 1'b0;
      drive(1'b0, 64'h0, 2'b00, 5'd0, 1'b0, 1'b0);
      #12;
      chk("rst_count", 64'(bus.Count), 64'd0);
      chk("rst_inready", 64'(bus.InReady), 64'd1);
      chk("rst_outvalid", 64'(bus.OutValid), 64'd0);
      reset_n = 1'b1;
      step();

      // single push/pop
      drive(1'b1, 64'hFFFFFFFF_3F800000, 2'b00, 5'd5, 1'b0, 1'b1);
      step();
      chk("t1_valid", 64'(bus.OutValid), 64'd1);
      chk("t1_imm", bus.ImmW, 64'hFFFFFFFF3F800000);
      chk("t1_rd", 64'(bus.RdW), 64'd5);
      chk("t1_err", 64'(bus.BoxErr), 64'd0);
      drive(1'b0, 64'h0, 2'b00, 5'd0, 1'b0, 1'b1);
      step();
      chk("t1_count", 64'(bus.Count), 64'd0);

      // fill, full ignore, drain
      drive(1'b1, 64'h4000000000000000, 2'b01, 5'd1, 1'b0, 1'b0);
      step();
      drive(1'b1, 64'h3FF0000000000000, 2'b01, 5'd2, 1'b0, 1'b0);
      step();
      chk("t2_count", 64'(bus.Count), 64'd2);
      chk("t2_inready", 64'(bus.InReady), 64'd0);
      drive(1'b1, 64'h1234, 2'b01, 5'd3, 1'b0, 1'b0);
      step();
      chk("t2_full_count", 64'(bus.Count), 64'd2);
      chk("t2_head1", 64'(bus.RdW), 64'd1);
      drive(1'b0, 64'h0, 2'b00, 5'd0, 1'b0, 1'b1);
      step();
      chk("t2_head2", 64'(bus.RdW), 64'd2);
      step();
      chk("t2_empty", 64'(bus.Count), 64'd0);

      // NaN-box checks
      drive(1'b1, 64'h00000000_3F800000, 2'b00, 5'd7, 1'b0, 1'b1);
      step();
      chk("t3_single_bad", 64'(bus.BoxErr), 64'd1);
      drive(1'b1, 64'hFFFFFFFFFFFFFFFF, 2'b11, 5'd8, 1'b0, 1'b1);
      step();
      chk("t3_quad_bad", 64'(bus.BoxErr), 64'd1);
      chk("t3_quad_imm", bus.ImmW, 64'hFFFFFFFFFFFFFFFF);
      drive(1'b1, 64'hFFFFFFFFFFFF3C00, 2'b10, 5'd9, 1'b0, 1'b1);
      step();
      chk("t3_half_ok", 64'(bus.BoxErr), 64'd0);
      chk("t3_half_fmt", 64'(bus.FmtW), 64'd2);
      drive(1'b0, 64'h0, 2'b00, 5'd0, 1'b0, 1'b1);
      step();

      // flush with simultaneous push
      drive(1'b1, 64'hFFFFFFFF_40000000, 2'b00, 5'd4, 1'b0, 1'b0);
      step();
      chk("t4_count1", 64'(bus.Count), 64'd1);
      drive(1'b1, 64'hFFFFFFFF_40400000, 2'b00, 5'd6, 1'b1, 1'b0);
      step();
      chk("t4_count", 64'(bus.Count), 64'd0);
      chk("t4_outvalid", 64'(bus.OutValid), 64'd0);
      chk("t4_inready", 64'(bus.InReady), 64'd1);

      // streaming with pointer wrap
      for (int i = 0; i < 7; i++) begin
         drive(1'b1, 64'hFFFFFFFF_00000000 | 64'(i), 2'b00, 5'(i), 1'b0, 1'b1);
         step();
         chk("t5_rd", 64'(bus.RdW), 64'(i));
         chk("t5_count", 64'(bus.Count), 64'd1);
      end
      drive(1'b0, 64'h0, 2'b00, 5'd0, 1'b0, 1'b1);
      step();

      // random traffic
      for (int n = 0; n < 600; n++) begin
         logic [63:0] imm;
         imm = {$urandom, $urandom};
         if ($urandom_range(0, 1) == 0) imm[63:32] = 32'hFFFF_FFFF;
         if ($urandom_range(0, 2) == 0) imm[63:16] = {48{1'b1}};
         drive(1'($urandom_range(0, 3) != 0), imm, 2'($urandom), 5'($urandom),
               1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 2) != 0));
         step();
      end

      // async reset mid-cycle with a full queue
      drive(1'b0, 64'h0, 2'b00, 5'd0, 1'b1, 1'b0);
      step();
      drive(1'b1, 64'hFFFFFFFF_3F800000, 2'b00, 5'd10, 1'b0, 1'b0);
      step();
      drive(1'b1, 64'hFFFFFFFF_3F800000, 2'b00, 5'd11, 1'b0, 1'b0);
      step();
      chk("t6_full", 64'(bus.Count), 64'd2);
      #2;
      reset_n = 1'b0;
      #1;
      chk("t6_count", 64'(bus.Count), 64'd0);
      chk("t6_outvalid", 64'(bus.OutValid), 64'd0);
      chk("t6_inready", 64'(bus.InReady), 64'd1);
      drive(1'b0, 64'h0, 2'b00, 5'd0, 1'b0, 1'b0);
      step();
      #3;
      reset_n = 1'b1;
      step();
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
